// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        ERROR
    } fetch_state_e;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ROM addressing and a registered IF/ID
// output with valid/ready handshake, redirects, EBREAK halt and misalignment stop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              AWIDTH   = 8,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_instr,
    output logic              halted,
    output logic              fetch_err
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;
    logic            r_halted;
    logic            r_err;

    logic            w_accept;
    logic            w_aligned;
    logic            w_is_ebreak;

    assign w_accept    = !r_valid || if_ready;
    assign w_aligned   = (redirect_pc[1:0] == 2'b00);
    assign w_is_ebreak = (imem_rdata == XLEN'(INSTR_EBREAK));
    assign imem_addr   = r_pc[AWIDTH+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else if (r_state != ERROR) begin
            // Redirect outranks capture, EBREAK detection and stall in RUN and HALTED.
            if (redirect_valid) begin
                r_valid  <= 1'b0;
                r_halted <= 1'b0;
                if (w_aligned) begin
                    r_pc    <= redirect_pc;
                    r_state <= RUN;
                end else begin
                    r_state <= ERROR;
                    r_err   <= 1'b1;
                end
            end else if (r_state == RUN) begin
                if (w_accept) begin
                    r_if_instr <= imem_rdata;
                    r_if_pc    <= r_pc;
                    r_valid    <= 1'b1;
                    r_pc       <= r_pc + XLEN'(PC_STEP);
                    if (w_is_ebreak) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end
                end
            end else if (r_valid && if_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign if_valid  = r_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign halted    = r_halted;
    assign fetch_err = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch stream.
module tb_fetch_unit;

    localparam int AWIDTH = 8;
    localparam int XLEN   = 32;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic              clk;
    logic              rst_n;
    logic [AWIDTH-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              if_ready;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_instr;
    logic              halted;
    logic              fetch_err;

    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_mode; // 0 running, 1 halted, 2 error

    fetch_unit #(
        .AWIDTH  (AWIDTH),
        .XLEN    (XLEN),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_ready      (if_ready),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit allow_ebreak);
        for (int i = 0; i < 256; i++) begin
            if (allow_ebreak && ($urandom % 10 == 0)) mem[i] = EBRK;
            else begin
                mem[i] = $urandom;
                if (mem[i] == EBRK) mem[i] = 32'h1234_5678;
            end
        end
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        rst_n          = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_mem(0);
        rst_n = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== mem[i]) begin
                bad++;
                $display("FAIL stream_%0d got=(%b,%h,%h) exp=(1,%h,%h)", i, if_valid, if_pc, if_instr, 32'(4 * i), mem[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== mem[1]) begin
                bad++;
                $display("FAIL stall_hold_%0d got=(%b,%h,%h) exp=(1,4,%h)", i, if_valid, if_pc, if_instr, mem[1]);
            end
        end
        if_ready = 1'b1;
        step();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== mem[2]) begin
            bad++;
            $display("FAIL stall_release got=(%b,%h,%h) exp=(1,8,%h)", if_valid, if_pc, if_instr, mem[2]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        if_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", if_valid); end
        redirect_valid = 1'b0;
        step();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem[16]) begin
            bad++;
            $display("FAIL redir_target got=(%b,%h,%h) exp=(1,40,%h)", if_valid, if_pc, if_instr, mem[16]);
        end
        if_ready = 1'b1;
    endtask

    task automatic test_halt();
        mem[2] = EBRK;
        do_reset();
        step();
        step();
        step();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== EBRK || halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_deliver got=(%b,%h,%h,h%b) exp=(1,8,%h,h1)", if_valid, if_pc, if_instr, halted, EBRK);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'd3) begin
                bad++;
                $display("FAIL halt_idle_%0d got=(%b,h%b,a%h) exp=(0,h1,a03)", i, if_valid, halted, imem_addr);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL halt_resume got=(h%b,%b) exp=(h0,0)", halted, if_valid); end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0]) begin
            bad++;
            $display("FAIL halt_refetch got=(%b,%h,%h) exp=(1,0,%h)", if_valid, if_pc, if_instr, mem[0]);
        end
        mem[2] = 32'h0000_0013;
    endtask

    task automatic test_error();
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        total++; if (fetch_err !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL err_enter got=(e%b,%b) exp=(e1,0)", fetch_err, if_valid); end
        total++; if (imem_addr !== 8'd1) begin bad++; $display("FAIL err_pc_hold got=%h exp=01", imem_addr); end
        redirect_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (fetch_err !== 1'b1 || if_valid !== 1'b0) begin
                bad++;
                $display("FAIL err_sticky_%0d got=(e%b,%b) exp=(e1,0)", i, fetch_err, if_valid);
            end
        end
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", fetch_err); end
    endtask

    task automatic test_alias();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        step();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL alias_bubble got=%b exp=0", if_valid); end
        step();
        total++;
        if (if_pc !== 32'h3FC || if_instr !== mem[255] || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL alias_top got=(%h,%h,a%h) exp=(3fc,%h,a00)", if_pc, if_instr, imem_addr, mem[255]);
        end
        step();
        total++;
        if (if_pc !== 32'h400 || if_instr !== mem[0]) begin
            bad++;
            $display("FAIL alias_wrap got=(%h,%h) exp=(400,%h)", if_pc, if_instr, mem[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=(%b,%h,%h,%b,%b) exp=(0,0,0,0,0)", if_valid, if_pc, if_instr, halted, fetch_err);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ipc   = 32'h0;
        m_instr = 32'h0;
        m_valid = 0;
        m_mode  = 0;
    endtask

    task automatic test_random();
        logic [31:0] rom_word;
        logic [31:0] r;
        fill_mem(1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 75 == 0) begin
                do_reset();
                model_reset();
            end
            redirect_valid = ($urandom % 8 == 0);
            r = $urandom % 16;
            if (r == 0) redirect_pc = 32'hFFFF_FFFC;
            else if (r == 1) redirect_pc = ($urandom & 32'h3FC) | 32'(1 + $urandom % 3);
            else redirect_pc = $urandom & 32'h3FC;
            if_ready = ($urandom % 4 != 0);
            rom_word = mem[(m_pc >> 2) % 256];
            step();
            if (m_mode != 2) begin
                if (redirect_valid) begin
                    m_valid = 0;
                    if (redirect_pc % 4 == 0) begin
                        m_pc   = redirect_pc;
                        m_mode = 0;
                    end else m_mode = 2;
                end else if (m_mode == 0 && (!m_valid || if_ready)) begin
                    m_ipc   = m_pc;
                    m_instr = rom_word;
                    m_valid = 1;
                    m_pc    = m_pc + 4;
                    if (rom_word == EBRK) m_mode = 1;
                end else if (m_mode == 1 && m_valid && if_ready) m_valid = 0;
            end
            total++;
            if (if_valid !== m_valid || halted !== (m_mode == 1) || fetch_err !== (m_mode == 2)) begin
                bad++;
                $display("FAIL rnd_flags cyc=%0d got=(v%b,h%b,e%b) exp=(v%b,h%b,e%b)", cyc, if_valid, halted, fetch_err, m_valid, m_mode == 1, m_mode == 2);
            end
            total++;
            if (if_pc !== m_ipc || if_instr !== m_instr) begin
                bad++;
                $display("FAIL rnd_data cyc=%0d got=(%h,%h) exp=(%h,%h)", cyc, if_pc, if_instr, m_ipc, m_instr);
            end
            total++;
            if (imem_addr !== 8'((m_pc >> 2) % 256)) begin
                bad++;
                $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, 8'((m_pc >> 2) % 256));
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_error();
        test_alias();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
